// File: rtl/activation_ctrl_pkg.sv
// Shared types and constants for the activation controller.
package activation_ctrl_pkg;

    // Default width of the per-layer word counter.
    localparam int unsigned CNT_W_DEFAULT = 10;

    // Activation modes understood by the datapath; codes above LEAKY are rejected.
    typedef enum logic [2:0] {
        RELU   = 3'b000,
        THRESH = 3'b001,
        IDENT  = 3'b010,
        LEAKY  = 3'b011
    } act_mode_e;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    // True when a requested mode code maps onto a supported activation.
    function automatic logic mode_valid(input logic [2:0] mode);
        return mode <= 3'(LEAKY);
    endfunction

endpackage

// File: rtl/activation_ctrl.sv
// Activation controller: sequences one layer of 64-bit words from the bias stage through an
// externally instanced activation datapath into the output buffer, with a single stage register.
// Optional feature: define ACT_CTRL_STATS_EN to add the zero_count output and its counter.
module activation_ctrl
    import activation_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [2:0]       cfg_mode,
    input  logic             cfg_float,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [63:0]      act_inputs,
    output logic [2:0]       act_mode,
    output logic             act_float,
    input  logic [63:0]      act_outputs,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef ACT_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] zero_count
`endif
);

    state_e           state_q, state_d;
    logic [63:0]      stage_q, stage_d;
    logic             stage_valid_q, stage_valid_d;
    logic             stage_last_q, stage_last_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [2:0]       mode_q, mode_d;
    logic             float_q, float_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic accept;
    logic out_hs;
    logic cfg_accept;

    // Handshake decode and output drive; the stage register feeds the datapath directly.
    always_comb begin
        in_ready   = (state_q == RUN) && (!stage_valid_q || out_ready);
        accept     = in_valid && in_ready;
        out_hs     = stage_valid_q && out_ready;
        cfg_accept = (state_q == IDLE) && start && mode_valid(cfg_mode) && (cfg_count != '0);
        act_inputs = stage_q;
        act_mode   = mode_q;
        act_float  = float_q;
        out_data   = act_outputs;
        out_valid  = stage_valid_q;
        out_last   = stage_valid_q && stage_last_q;
        busy       = (state_q != IDLE);
        done       = done_q;
        err        = err_q;
    end

    // Next-state logic for the sequencer, stage register and layer counter.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        stage_valid_d = stage_valid_q;
        stage_last_d  = stage_last_q;
        remaining_d   = remaining_q;
        mode_d        = mode_q;
        float_d       = float_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!mode_valid(cfg_mode)) begin
                        err_d = 1'b1;
                    end else if (cfg_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d        = cfg_mode;
                        float_d       = cfg_float;
                        remaining_d   = cfg_count;
                        stage_valid_d = 1'b0;
                        stage_last_d  = 1'b0;
                        state_d       = RUN;
                    end
                end
            end
            RUN, DRAIN: begin
                if (abort) begin
                    // Abandon the layer: staged word dropped, no completion reported.
                    state_d       = IDLE;
                    stage_valid_d = 1'b0;
                    stage_last_d  = 1'b0;
                    remaining_d   = '0;
                end else begin
                    if (out_hs) begin
                        stage_valid_d = 1'b0;
                    end
                    if (accept) begin
                        stage_d       = in_data;
                        stage_valid_d = 1'b1;
                        stage_last_d  = (remaining_q == CNT_W'(1));
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                    // In DRAIN the stage always holds the final word of the layer.
                    if ((state_q == DRAIN) && out_hs) begin
                        state_d      = IDLE;
                        stage_last_d = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                stage_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_last_q  <= 1'b0;
            remaining_q   <= '0;
            mode_q        <= 3'(RELU);
            float_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            stage_last_q  <= stage_last_d;
            remaining_q   <= remaining_d;
            mode_q        <= mode_d;
            float_q       <= float_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

`ifdef ACT_CTRL_STATS_EN
    logic [CNT_W-1:0] zero_q;

    // Saturating count of all-zero words handed to the output buffer since the last start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            zero_q <= '0;
        end else if (cfg_accept) begin
            zero_q <= '0;
        end else if (out_hs && (act_outputs == 64'h0) && (zero_q != '1)) begin
            zero_q <= zero_q + CNT_W'(1);
        end
    end

    assign zero_count = zero_q;
`else
    logic unused_cfg_accept;
    assign unused_cfg_accept = cfg_accept;
`endif

endmodule

// File: tb/tb_activation_ctrl.sv
// Directed self-checking bench for activation_ctrl with a byte-lane ReLU/identity datapath model.
// Define ACT_CTRL_STATS_EN to also exercise zero_count.
module tb_activation_ctrl;
    import activation_ctrl_pkg::*;

    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    cfg_mode = 3'd0;
    logic          cfg_float = 1'b0;
    logic [CW-1:0] cfg_count = '0;
    logic          abort = 1'b0;
    logic [63:0]   in_data = 64'h0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   act_inputs;
    logic [2:0]    act_mode;
    logic          act_float;
    logic [63:0]   act_outputs;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;
`ifdef ACT_CTRL_STATS_EN
    logic [CW-1:0] zero_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] got_data[$];
    logic        got_last[$];
    logic        done_seen;

    activation_ctrl #(
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .cfg_float  (cfg_float),
        .cfg_count  (cfg_count),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act_inputs (act_inputs),
        .act_mode   (act_mode),
        .act_float  (act_float),
        .act_outputs(act_outputs),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef ACT_CTRL_STATS_EN
        ,
        .zero_count (zero_count)
`endif
    );

    always #5 clk = ~clk;

    // Datapath stand-in: signed byte-lane ReLU in mode 000, pass-through otherwise.
    always_comb begin
        act_outputs = act_inputs;
        if (act_mode == 3'b000) begin
            for (int i = 0; i < 8; i++) begin
                if (act_inputs[8*i+7]) act_outputs[8*i +: 8] = 8'h00;
            end
        end
    end

    // Record output handshakes mid-cycle, when valid/ready are stable.
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish before 100us");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] mode, input logic [CW-1:0] cnt, input logic flt);
        start     = 1'b1;
        cfg_mode  = mode;
        cfg_count = cnt;
        cfg_float = flt;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Reset values, applied asynchronously between clock edges.
        #2 n_rst = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h0);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_out_last", 64'(out_last), 64'h0);
        check_eq("rst_act_mode", 64'(act_mode), 64'h0);
        check_eq("rst_act_float", 64'(act_float), 64'h0);
        check_eq("rst_done", 64'(done), 64'h0);
        check_eq("rst_err", 64'(err), 64'h0);
        step();
        step();
        n_rst = 1'b1;
        step();

        // ReLU layer of three words at full throughput.
        do_start(3'b000, CW'(3), 1'b0);
        check_eq("t1_busy", 64'(busy), 64'h1);
        check_eq("t1_act_mode", 64'(act_mode), 64'h0);
        check_eq("t1_in_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h80FF_0102_7F00_8001;
        step();
        check_eq("t1_w0_valid", 64'(out_valid), 64'h1);
        check_eq("t1_w0_data", out_data, 64'h0000_0102_7F00_0001);
        check_eq("t1_w0_last", 64'(out_last), 64'h0);
        in_data = 64'h0;
        step();
        check_eq("t1_w1_data", out_data, 64'h0);
        check_eq("t1_w1_last", 64'(out_last), 64'h0);
        in_data = 64'h0101_0101_0101_0101;
        step();
        check_eq("t1_w2_data", out_data, 64'h0101_0101_0101_0101);
        check_eq("t1_w2_last", 64'(out_last), 64'h1);
        check_eq("t1_drain_in_ready", 64'(in_ready), 64'h0);
        check_eq("t1_done_early", 64'(done), 64'h0);
        in_valid = 1'b0;
        step();
        check_eq("t1_done", 64'(done), 64'h1);
        check_eq("t1_busy_end", 64'(busy), 64'h0);
        check_eq("t1_out_valid_end", 64'(out_valid), 64'h0);
        step();
        check_eq("t1_done_pulse", 64'(done), 64'h0);

        // Bad mode is rejected; zero-length layer completes immediately.
        do_start(3'b101, CW'(3), 1'b1);
        check_eq("t2_err", 64'(err), 64'h1);
        check_eq("t2_busy", 64'(busy), 64'h0);
        check_eq("t2_in_ready", 64'(in_ready), 64'h0);
        check_eq("t2_mode_kept", 64'(act_mode), 64'h0);
        check_eq("t2_float_kept", 64'(act_float), 64'h0);
        step();
        check_eq("t2_err_pulse", 64'(err), 64'h0);
        do_start(3'b010, CW'(0), 1'b0);
        check_eq("t2_zero_done", 64'(done), 64'h1);
        check_eq("t2_zero_err", 64'(err), 64'h0);
        check_eq("t2_zero_busy", 64'(busy), 64'h0);
        step();

        // Backpressure on word 2; a start mid-layer is ignored.
        got_data.delete();
        got_last.delete();
        do_start(3'b010, CW'(4), 1'b1);
        check_eq("t3_act_float", 64'(act_float), 64'h1);
        in_valid = 1'b1;
        in_data  = 64'h1111_1111_1111_1111;
        step();
        in_data = 64'h2222_2222_2222_2222;
        step();
        out_ready = 1'b0;
        in_data   = 64'h3333_3333_3333_3333;
        #1;
        check_eq("t3_stall_in_ready", 64'(in_ready), 64'h0);
        step();
        check_eq("t3_hold0", out_data, 64'h2222_2222_2222_2222);
        start    = 1'b1;
        cfg_mode = 3'b101;
        step();
        start = 1'b0;
        check_eq("t3_hold1", out_data, 64'h2222_2222_2222_2222);
        check_eq("t3_start_ignored_err", 64'(err), 64'h0);
        check_eq("t3_start_ignored_mode", 64'(act_mode), 64'h2);
        step();
        check_eq("t3_hold2", out_data, 64'h2222_2222_2222_2222);
        check_eq("t3_hold_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        step();
        in_data = 64'h4444_4444_4444_4444;
        step();
        in_valid = 1'b0;
        step();
        check_eq("t3_done", 64'(done), 64'h1);
        check_eq("t3_count", 64'(got_data.size()), 64'd4);
        if (got_data.size() == 4) begin
            check_eq("t3_ord0", got_data[0], 64'h1111_1111_1111_1111);
            check_eq("t3_ord1", got_data[1], 64'h2222_2222_2222_2222);
            check_eq("t3_ord2", got_data[2], 64'h3333_3333_3333_3333);
            check_eq("t3_ord3", got_data[3], 64'h4444_4444_4444_4444);
            check_eq("t3_last_lo", 64'(got_last[2]), 64'h0);
            check_eq("t3_last_hi", 64'(got_last[3]), 64'h1);
        end

        // Abort after two of five words, then a one-word layer.
        do_start(3'b000, CW'(5), 1'b0);
        in_valid = 1'b1;
        in_data  = 64'h0102_0304_0506_0708;
        step();
        in_data = 64'h1020_3040_5060_7070;
        step();
        in_valid = 1'b0;
        abort    = 1'b1;
        step();
        abort = 1'b0;
        check_eq("t4_abort_busy", 64'(busy), 64'h0);
        check_eq("t4_abort_valid", 64'(out_valid), 64'h0);
        check_eq("t4_abort_done", 64'(done), 64'h0);
        check_eq("t4_abort_err", 64'(err), 64'h0);
        step();
        check_eq("t4_no_done_later", 64'(done), 64'h0);
        do_start(3'b000, CW'(1), 1'b0);
        in_valid = 1'b1;
        in_data  = 64'h7F80_7F80_7F80_7F80;
        step();
        in_valid = 1'b0;
        check_eq("t4_single_data", out_data, 64'h7F00_7F00_7F00_7F00);
        check_eq("t4_single_last", 64'(out_last), 64'h1);
        step();
        check_eq("t4_single_done", 64'(done), 64'h1);

        // Asynchronous reset in the middle of a layer.
        do_start(3'b011, CW'(3), 1'b1);
        check_eq("t5_mode_pre", 64'(act_mode), 64'h3);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0001;
        step();
        in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check_eq("t5_busy", 64'(busy), 64'h0);
        check_eq("t5_out_valid", 64'(out_valid), 64'h0);
        check_eq("t5_out_last", 64'(out_last), 64'h0);
        check_eq("t5_act_mode", 64'(act_mode), 64'h0);
        check_eq("t5_act_float", 64'(act_float), 64'h0);
        check_eq("t5_act_inputs", act_inputs, 64'h0);
        step();
        n_rst     = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            done_seen = done_seen | done;
        end
        check_eq("t5_no_done", 64'(done_seen), 64'h0);

`ifdef ACT_CTRL_STATS_EN
        // Two ReLU-zeroed words out of four, then cleared by the next start.
        do_start(3'b000, CW'(4), 1'b0);
        in_valid = 1'b1;
        in_data  = 64'h8080_8080_8080_8080;
        step();
        in_data = 64'h0101_0101_0101_0101;
        step();
        in_data = 64'h0;
        step();
        in_data = 64'h0202_0202_0202_0202;
        step();
        in_valid = 1'b0;
        step();
        check_eq("t6_done", 64'(done), 64'h1);
        check_eq("t6_zero_count", 64'(zero_count), 64'd2);
        do_start(3'b000, CW'(1), 1'b0);
        check_eq("t6_zero_clear", 64'(zero_count), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'h0303_0303_0303_0303;
        step();
        in_valid = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/activation_ctrl.md
ACTIVATION_CTRL -- requirements
Module: activation_ctrl

Interface
REQ-001 Parameter CNT_W, default 10, width of the per-layer word counter (max 2^CNT_W-1 words per layer).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; latches cfg_* when IDLE.
REQ-005 cfg_mode  input  3  activation mode (000 relu, 001 threshold, 010 identity, 011 leaky relu).
REQ-006 cfg_float  input  1  1 = float8 lanes, 0 = signed fixed lanes.
REQ-007 cfg_count  input  CNT_W  number of 64-bit words in the layer.
REQ-008 abort  input  1  synchronous abandon of the current layer.
REQ-009 in_data / in_valid / in_ready  input 64 / input 1 / output 1  biased-word stream from the bias stage.
REQ-010 act_inputs / act_mode / act_float  output 64 / 3 / 1  drive of the activation datapath.
REQ-011 act_outputs  input  64  combinational result from the activation datapath.
REQ-012 out_data / out_valid / out_ready / out_last  output 64 / output 1 / input 1 / output 1  activated-word stream to the output buffer.
REQ-013 busy / done / err  output 1 each  layer in progress / one-cycle completion pulse / one-cycle bad-config pulse.

Function
REQ-014 States IDLE, RUN, DRAIN; IDLE on reset.
REQ-015 IDLE: in_ready=0, out_valid=0, busy=0.
REQ-016 IDLE + start + cfg_mode>3 -> err=1 next cycle, stay IDLE, config not latched.
REQ-017 IDLE + start + cfg_count=0 (valid mode) -> done=1 next cycle, stay IDLE.
REQ-018 IDLE + start + valid cfg -> latch mode/float into act_mode/act_float, remaining=cfg_count, enter RUN, busy=1; act_mode/act_float stable until next accepted start.
REQ-019 Single stage register: in_ready = RUN && (!stage_valid || out_ready); word accepted on in_valid&&in_ready loads stage register, sets stage_valid.
REQ-020 act_inputs = stage register; out_data = act_outputs; out_valid = stage_valid; latency: accepted in cycle N -> out_data valid in cycle N+1.
REQ-021 Simultaneous out handshake and input accept -> stage reloaded, stage_valid stays 1 (full throughput, one word/cycle).
REQ-022 out handshake without accept -> stage_valid=0.
REQ-023 remaining decrements by 1 per accepted word (CNT_W bits, never wraps); acceptance of the word with remaining=1 -> DRAIN, in_ready=0.
REQ-024 out_last=1 iff out_valid and the staged word is the layer's final word.
REQ-025 DRAIN: on out handshake of last word -> done=1 for one cycle, IDLE, busy=0 same cycle as done.
REQ-026 start while RUN or DRAIN ignored, no err.
REQ-027 abort in RUN/DRAIN -> next cycle IDLE, stage_valid=0, no done, no err; abort in IDLE ignored; abort has priority over start in the same cycle.
REQ-028 out_data held stable while out_valid=1 and out_ready=0.

Reset
REQ-029 n_rst low -> immediately: state IDLE, stage register 0, stage_valid 0, remaining 0, act_mode 000, act_float 0, busy/done/err/out_last 0.
REQ-030 Reset mid-layer discards the layer; no done after release.

Configuration
REQ-031 Macro ACT_CTRL_STATS_EN defined -> extra output zero_count (CNT_W) counting out handshakes whose out_data==64'h0, cleared on accepted start and reset, saturating at all-ones.
REQ-032 Macro undefined -> no zero_count port, no counter logic; all other behaviour identical.

Structure
REQ-033 Shared package holds mode enumeration (RELU, THRESH, IDENT, LEAKY) and state enumeration; CNT_W default as package constant.
REQ-034 No sub-module; activation datapath instanced by parent and wired to act_* ports.

Verification
REQ-035 start, mode 000, float 0, count 3, in 64'h80FF_0102_7F00_8001, 64'h0, 64'h0101..01, out_ready=1 -> three outputs, first 64'h0000_0102_7F00_0001, out_last on third, done one cycle after third handshake.
REQ-036 start mode 101 -> err pulse, busy 0, in_ready 0; start count 0 mode 010 -> done pulse only.
REQ-037 count 4, out_ready low 3 cycles on word 2 -> out_data held, in_ready 0, no loss/duplication, order preserved.
REQ-038 abort after 2 of 5 words -> IDLE next cycle, no done; next start count 1 completes normally.
REQ-039 n_rst asserted mid-RUN -> outputs at reset values asynchronously, no done after release.
REQ-040 ACT_CTRL_STATS_EN: count 4, two zero outputs -> zero_count=2 after done, 0 after next start.
